gsim_result_buffer: RTL and testbench

- Downstream stage of the GSIM solver. Captures each solved vector (FRAME_LEN Q16.16 words, streamed with a valid strobe) into a ping-pong buffer.
- Replays each captured vector over a valid/ready stream to the consumer, so the solver never stalls on a slow sink.
- Filters malformed bursts and reports errors through sticky flags.

---
 rtl/gsim_result_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_gsim_result_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_result_buffer.sv
// gsim_result_buffer: ping-pong capture of GSIM solved vectors, replayed on a
// valid/ready stream. Malformed bursts are filtered and flagged (sticky).
// Optional build macro GSIM_RB_SAT16_EN: out_data carries the Q16.16 word
// rounded to nearest integer and saturated to signed 16 bits, sign-extended.
module gsim_result_buffer #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        frames_done,
  output logic              short_err,
  output logic              ovf_err
);

  localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wr_st_t;
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_TAIL} rd_st_t;

  logic [DATA_W-1:0] mem [2][FRAME_LEN];

  bank_st_t bank_st [2];
  bank_st_t bank_n  [2];

  wr_st_t           wr_st, wr_st_n;
  logic [IDX_W-1:0] wr_idx, wr_idx_n;
  logic             wr_bank, wr_bank_n;

  rd_st_t           rd_st, rd_st_n;
  logic [IDX_W-1:0] rd_idx, rd_idx_n;
  logic             rd_bank, rd_bank_n;

  logic             wr_en_c, fill_start_c, commit_c, short_c, ovf_c;
  logic             load_c, load_bank_c, load_last_c, clr_valid_c;
  logic [IDX_W-1:0] load_idx_c;
  logic             drain_start_c, drain_bank_c, done_c;
  logic             hs_c;
  logic [1:0]       bank_avail_c;

`ifdef GSIM_RB_SAT16_EN
  localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'(32767);
  localparam logic signed [DATA_W:0] SAT_MIN = (DATA_W+1)'(-32768);

  // Round Q16.16 to nearest integer, saturate to signed 16 bits.
  function automatic logic [DATA_W-1:0] conv_word(input logic [DATA_W-1:0] w);
    logic signed [DATA_W:0] sum;
    logic signed [DATA_W:0] shr;
    sum = $signed({w[DATA_W-1], w}) + $signed({{(DATA_W-15){1'b0}}, 16'h8000});
    shr = sum >>> 16;
    if (shr > SAT_MAX)      conv_word = DATA_W'(32767);
    else if (shr < SAT_MIN) conv_word = {{(DATA_W-16){1'b1}}, 16'h8000};
    else                    conv_word = shr[DATA_W-1:0];
  endfunction
`else
  // Stored word passes through bit-exact.
  function automatic logic [DATA_W-1:0] conv_word(input logic [DATA_W-1:0] w);
    conv_word = w;
  endfunction
`endif

  assign hs_c = out_valid & out_ready;

  // A bank can start draining if it is FULL or is being committed this cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_avail_c[b] = (bank_st[b] == B_FULL) || (commit_c && (wr_bank == 1'(b)));
    end
  end

  // Write side: run start / fill / commit / short-run / overflow decisions.
  always_comb begin
    wr_st_n      = wr_st;
    wr_idx_n     = wr_idx;
    wr_bank_n    = wr_bank;
    wr_en_c      = 1'b0;
    fill_start_c = 1'b0;
    commit_c     = 1'b0;
    short_c      = 1'b0;
    ovf_c        = 1'b0;
    case (wr_st)
      W_IDLE: begin
        if (in_valid) begin
          if (bank_st[wr_bank] == B_EMPTY) begin
            wr_en_c      = 1'b1;
            fill_start_c = 1'b1;
            wr_idx_n     = IDX_W'(1);
            wr_st_n      = W_FILL;
          end else begin
            ovf_c   = 1'b1;
            wr_st_n = W_SKIP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          wr_en_c = 1'b1;
          if (wr_idx == LAST_IDX) begin
            commit_c  = 1'b1;
            wr_idx_n  = '0;
            wr_bank_n = ~wr_bank;
            wr_st_n   = W_SKIP;
          end else begin
            wr_idx_n = wr_idx + IDX_W'(1);
          end
        end else begin
          short_c  = 1'b1;
          wr_idx_n = '0;
          wr_st_n  = W_IDLE;
        end
      end
      W_SKIP: begin
        if (!in_valid) wr_st_n = W_IDLE;
      end
      default: wr_st_n = W_IDLE;
    endcase
  end

  // Read side: load the output register and hand off between banks.
  always_comb begin
    rd_st_n       = rd_st;
    rd_idx_n      = rd_idx;
    rd_bank_n     = rd_bank;
    load_c        = 1'b0;
    load_bank_c   = rd_bank;
    load_idx_c    = rd_idx;
    clr_valid_c   = 1'b0;
    drain_start_c = 1'b0;
    drain_bank_c  = rd_bank;
    done_c        = 1'b0;
    case (rd_st)
      R_IDLE: begin
        if (bank_avail_c[rd_bank]) begin
          load_c        = 1'b1;
          load_idx_c    = '0;
          drain_start_c = 1'b1;
          rd_idx_n      = IDX_W'(1);
          rd_st_n       = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (hs_c) begin
          load_c = 1'b1;
          if (rd_idx == LAST_IDX) rd_st_n = R_TAIL;
          else                    rd_idx_n = rd_idx + IDX_W'(1);
        end
      end
      R_TAIL: begin
        if (hs_c) begin
          done_c    = 1'b1;
          rd_bank_n = ~rd_bank;
          if (bank_avail_c[~rd_bank]) begin
            load_c        = 1'b1;
            load_bank_c   = ~rd_bank;
            load_idx_c    = '0;
            drain_start_c = 1'b1;
            drain_bank_c  = ~rd_bank;
            rd_idx_n      = IDX_W'(1);
            rd_st_n       = R_DRAIN;
          end else begin
            clr_valid_c = 1'b1;
            rd_idx_n    = '0;
            rd_st_n     = R_IDLE;
          end
        end
      end
      default: rd_st_n = R_IDLE;
    endcase
  end

  assign load_last_c = (load_idx_c == LAST_IDX);

  // Bank state merge: write updates first, read updates override on overlap.
  always_comb begin
    bank_n[0] = bank_st[0];
    bank_n[1] = bank_st[1];
    if (fill_start_c)  bank_n[wr_bank]      = B_FILLING;
    if (short_c)       bank_n[wr_bank]      = B_EMPTY;
    if (commit_c)      bank_n[wr_bank]      = B_FULL;
    if (done_c)        bank_n[rd_bank]      = B_EMPTY;
    if (drain_start_c) bank_n[drain_bank_c] = B_DRAINING;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_st[0] <= B_EMPTY;
      bank_st[1] <= B_EMPTY;
      wr_st      <= W_IDLE;
      wr_idx     <= '0;
      wr_bank    <= 1'b0;
      rd_st      <= R_IDLE;
      rd_idx     <= '0;
      rd_bank    <= 1'b0;
    end else begin
      bank_st[0] <= bank_n[0];
      bank_st[1] <= bank_n[1];
      wr_st      <= wr_st_n;
      wr_idx     <= wr_idx_n;
      wr_bank    <= wr_bank_n;
      rd_st      <= rd_st_n;
      rd_idx     <= rd_idx_n;
      rd_bank    <= rd_bank_n;
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_bank][wr_idx] <= x_in;
  end

  // Registered output stream and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frames_done <= 8'd0;
      short_err   <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      if (load_c) begin
        out_valid <= 1'b1;
        out_data  <= conv_word(mem[load_bank_c][load_idx_c]);
        out_last  <= load_last_c;
      end else if (clr_valid_c) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (done_c)  frames_done <= frames_done + 8'd1;
      if (short_c) short_err   <= 1'b1;
      if (ovf_c)   ovf_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gsim_result_buffer.sv
// Bench for gsim_result_buffer: run table plus hand sequences, with a
// scoreboard of expected output words checked on every handshake.
module tb_gsim_result_buffer;

  localparam int unsigned FL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] x_in;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [7:0]  frames_done;
  logic        short_err;
  logic        ovf_err;

  gsim_result_buffer #(.FRAME_LEN(FL), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .frames_done(frames_done),
    .short_err(short_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int unsigned nwords;
    logic [31:0] base;
    logic [31:0] step;
    logic        exp_short;
    logic        exp_ovf;
    logic [7:0]  exp_frames;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          nchecks = 0;
  int          nerrs   = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion of a stored word to the expected output word.
  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef GSIM_RB_SAT16_EN
    longint v;
    v = longint'($signed(w));
    v = (v + 64'sd32768) >>> 16;
    if (v > 64'sd32767)  v = 64'sd32767;
    if (v < -64'sd32768) v = -64'sd32768;
    return 32'(v);
`else
    return w;
`endif
  endfunction

  // One clock: observe at negedge (handshake, hold), then step past posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    if (!reset) begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchecks++;
          nerrs++;
          $display("FAIL unexpected_out: got data %h last %0b expected no transfer", out_data, out_last);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e.data);
          chk("last", 32'(out_last), 32'(e.last));
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end else begin
      hold_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one contiguous run; optionally push the first npush words and
  // check first-word latency when the read side is idle.
  task automatic send_words(input logic [31:0] words[$], input int unsigned npush,
                            input bit chk_lat);
    exp_t e;
    for (int k = 0; k < words.size(); k++) begin
      in_valid = 1'b1;
      x_in     = words[k];
      if (k < int'(npush)) begin
        e.data = exp_word(words[k]);
        e.last = (k == int'(FL) - 1);
        sb.push_back(e);
      end
      if (chk_lat && k == int'(FL) - 1) chk("early_valid", 32'(out_valid), 32'd0);
      tick();
      if (chk_lat && k == int'(FL) - 1) chk("latency_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    x_in     = '0;
  endtask

  task automatic build(input int unsigned n, input logic [31:0] base, input logic [31:0] step,
                       output logic [31:0] words[$]);
    words = {};
    for (int k = 0; k < int'(n); k++) words.push_back(base + 32'(k) * step);
  endtask

  task automatic drain(input int bound, output int cycles);
    cycles = 0;
    while (sb.size() > 0 && cycles < bound) begin
      tick();
      cycles++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    int          c;
    reset     = 1'b1;
    in_valid  = 1'b0;
    x_in      = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    chk("rst_short", 32'(short_err), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);

    vecs[0] = '{FL,      32'h0000_0000, 32'h0001_0000, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{FL + 1,  32'h1234_0000, 32'h0000_0001, 1'b0, 1'b0, 8'd2};
    vecs[2] = '{10,      32'h0BAD_0000, 32'h0000_0100, 1'b1, 1'b0, 8'd2};
    vecs[3] = '{FL,      32'hA5A5_0000, 32'h0000_0011, 1'b1, 1'b0, 8'd3};
    vecs[4] = '{1,       32'h7777_7777, 32'h0000_0000, 1'b1, 1'b0, 8'd3};
    vecs[5] = '{FL,      32'hFFFF_0000, 32'hFFFF_8001, 1'b1, 1'b0, 8'd4};

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      build(vecs[i].nwords, vecs[i].base, vecs[i].step, w);
      send_words(w, (vecs[i].nwords >= FL) ? FL : 0, vecs[i].nwords >= FL);
      tick();
      drain(100, c);
      repeat (2) tick();
      chk("tbl_short", 32'(short_err), 32'(vecs[i].exp_short));
      chk("tbl_ovf", 32'(ovf_err), 32'(vecs[i].exp_ovf));
      chk("tbl_frames", 32'(frames_done), 32'(vecs[i].exp_frames));
      chk("tbl_idle", 32'(out_valid), 32'd0);
    end

    // Backpressure: A and B buffered, C dropped, then back-to-back drain.
    out_ready = 1'b0;
    build(FL, 32'h000A_0000, 32'h0000_0101, w);
    send_words(w, FL, 1'b1);
    tick();
    build(FL, 32'h000B_0000, 32'h0000_0202, w);
    send_words(w, FL, 1'b0);
    tick();
    build(FL, 32'h000C_0000, 32'h0000_0303, w);
    send_words(w, 0, 1'b0);
    repeat (3) tick();
    chk("bp_ovf", 32'(ovf_err), 32'd1);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_data, sb[0].data);
    out_ready = 1'b1;
    drain(200, c);
    chk("bp_drain_cycles", 32'(c), 32'd32);
    tick();
    chk("bp_idle", 32'(out_valid), 32'd0);
    chk("bp_frames", 32'(frames_done), 32'd6);

    // Fixed-point words, optionally rounded/saturated.
    w = {32'h0001_8000, 32'hFFFE_8000, 32'h7FFF_FFFF, 32'h8000_0000};
    for (int k = 4; k < int'(FL); k++) w.push_back(32'h0000_4000 * 32'(k));
`ifdef GSIM_RB_SAT16_EN
    sb.push_back('{32'h0000_0002, 1'b0});
    sb.push_back('{32'hFFFF_FFFF, 1'b0});
    sb.push_back('{32'h0000_7FFF, 1'b0});
    sb.push_back('{32'hFFFF_8000, 1'b0});
    for (int k = 4; k < int'(FL); k++) sb.push_back('{exp_word(w[k]), k == int'(FL) - 1});
    send_words(w, 0, 1'b1);
`else
    send_words(w, FL, 1'b1);
`endif
    tick();
    drain(100, c);
    tick();
    chk("fx_frames", 32'(frames_done), 32'd7);

    // Random out_ready while sending and draining.
    rnd_ready = 1'b1;
    build(FL, 32'h5A00_0000, 32'h0103_0507, w);
    send_words(w, FL, 1'b0);
    tick();
    drain(600, c);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rnd_frames", 32'(frames_done), 32'd8);
    chk("rnd_idle", 32'(out_valid), 32'd0);

    // Reset during a drain plus a fill: nothing may follow.
    out_ready = 1'b0;
    build(FL, 32'h0E00_0000, 32'h0000_0001, w);
    send_words(w, 0, 1'b0);
    tick();
    build(5, 32'h0F00_0000, 32'h0000_0001, w);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x_in     = w[k];
      tick();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("rr_valid", 32'(out_valid), 32'd0);
    chk("rr_frames", 32'(frames_done), 32'd0);
    chk("rr_short", 32'(short_err), 32'd0);
    chk("rr_ovf", 32'(ovf_err), 32'd0);
    build(FL, 32'h0D00_0000, 32'h0000_0010, w);
    send_words(w, FL, 1'b1);
    tick();
    drain(100, c);
    tick();
    chk("rr_after_frames", 32'(frames_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
